// File: rtl/mux_arbiter.sv
// mux_arbiter: packet-level round-robin arbiter for a 2:1 output mux.
// Holds a grant from head to tail, flags protocol violations and counts transferred flits.
module mux_arbiter #(
    parameter int unsigned FLITW     = 66,
    parameter logic [1:0]  TYPE_NONE = 2'b00,
    parameter logic [1:0]  TYPE_HEAD = 2'b01,
    parameter logic [1:0]  TYPE_DATA = 2'b10,
    parameter logic [1:0]  TYPE_TAIL = 2'b11,
    parameter int unsigned CNTW      = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [FLITW-1:0] idata_0,
    input  logic             ivalid_0,
    input  logic [FLITW-1:0] idata_1,
    input  logic             ivalid_1,
    input  logic             oready,
    output logic [1:0]       sel,
    output logic             iready_0,
    output logic             iready_1,
    output logic             busy,
    output logic             err,
    output logic [CNTW-1:0]  flit_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic            prio_q, prio_d;
    logic            err_q, err_d;
    logic [1:0]      open_q, open_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [1:0] ftype [2];
    logic [1:0] ivalid;
    logic [1:0] gnt;
    logic [1:0] xfer;
    logic [1:0] req;
    logic       winner;
    logic       rearb;
    logic       unused_payload;

    assign ftype[0]       = idata_0[FLITW-1:FLITW-2];
    assign ftype[1]       = idata_1[FLITW-1:FLITW-2];
    assign unused_payload = ^{idata_0[FLITW-3:0], idata_1[FLITW-3:0]};
    assign ivalid         = {ivalid_1, ivalid_0};

    // Grant-side outputs decode from the state register only.
    assign gnt      = {state_q == GNT1, state_q == GNT0};
    assign sel      = gnt;
    assign busy     = |gnt;
    assign iready_0 = gnt[0] & oready;
    assign iready_1 = gnt[1] & oready;
    assign err      = err_q;
    assign flit_cnt = cnt_q;

    assign xfer   = ivalid & gnt & {2{oready}};
    assign req    = {ivalid[1] && (ftype[1] == TYPE_HEAD),
                     ivalid[0] && (ftype[0] == TYPE_HEAD)};
    assign winner = (&req) ? prio_q : req[1];

    // Next-state: arbitrate when idle or when the owner's tail transfers.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        err_d   = err_q;
        open_d  = open_q;
        cnt_d   = cnt_q;
        rearb   = 1'b0;

        case (state_q)
            IDLE:    rearb = 1'b1;
            GNT0:    rearb = xfer[0] && (ftype[0] == TYPE_TAIL);
            GNT1:    rearb = xfer[1] && (ftype[1] == TYPE_TAIL);
            default: rearb = 1'b1;
        endcase

        if (rearb) begin
            if (|req) begin
                state_d = winner ? GNT1 : GNT0;
                prio_d  = ~winner;
            end else begin
                state_d = IDLE;
            end
        end

        for (int k = 0; k < 2; k++) begin
            if (xfer[k]) begin
                if ((ftype[k] == TYPE_NONE) || ((ftype[k] == TYPE_HEAD) && open_q[k])) begin
                    err_d = 1'b1;
                end else if (ftype[k] == TYPE_HEAD) begin
                    open_d[k] = 1'b1;
                end else if (ftype[k] == TYPE_TAIL) begin
                    open_d[k] = 1'b0;
                end
            end
            // Body flit offered by an input that has no packet in flight.
            if (ivalid[k] && !gnt[k] && !open_q[k] &&
                ((ftype[k] == TYPE_DATA) || (ftype[k] == TYPE_TAIL))) begin
                err_d = 1'b1;
            end
        end

        if ((|xfer) && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            err_q   <= 1'b0;
            open_q  <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            err_q   <= err_d;
            open_q  <= open_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed and randomized packet traffic checked every cycle
// against a packet-ownership model of the arbiter.
module tb_mux_arbiter;

    localparam int unsigned FLITW = 66;
    localparam int unsigned CNTW  = 16;
    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_DATA = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    logic             clk;
    logic             rst_;
    logic [FLITW-1:0] idata_0, idata_1;
    logic             ivalid_0, ivalid_1, oready;
    logic [1:0]       sel;
    logic             iready_0, iready_1, busy, err;
    logic [CNTW-1:0]  flit_cnt;

    mux_arbiter #(.FLITW(FLITW), .CNTW(CNTW)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .idata_0  (idata_0),
        .ivalid_0 (ivalid_0),
        .idata_1  (idata_1),
        .ivalid_1 (ivalid_1),
        .oready   (oready),
        .sel      (sel),
        .iready_0 (iready_0),
        .iready_1 (iready_1),
        .busy     (busy),
        .err      (err),
        .flit_cnt (flit_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    // Model: which input owns the output (-1 = nobody), favoured input, error, count.
    int m_owner;
    int m_prio;
    bit m_err;
    int m_cnt;
    bit m_open [2];
    bit x_exp  [2];

    logic [1:0] q0[$];
    logic [1:0] q1[$];
    int gap [2];
    int max_gap;
    int ready_mode;
    int tcyc;
    int sel_log[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_prio    = 0;
        m_err     = 1'b0;
        m_cnt     = 0;
        m_open[0] = 1'b0;
        m_open[1] = 1'b0;
        x_exp[0]  = 1'b0;
        x_exp[1]  = 1'b0;
    endtask

    task automatic push_pkt(input int k, input int len);
        for (int i = 0; i < len; i++) begin
            logic [1:0] t;
            t = (i == 0) ? T_HEAD : (i == len - 1) ? T_TAIL : T_DATA;
            if (k == 0) q0.push_back(t);
            else        q1.push_back(t);
        end
    endtask

    task automatic drive();
        bit v0, v1;
        v0 = (q0.size() > 0) && (gap[0] == 0);
        v1 = (q1.size() > 0) && (gap[1] == 0);
        ivalid_0 = v0;
        ivalid_1 = v1;
        idata_0  = {(v0 ? q0[0] : 2'($urandom)), $urandom, $urandom};
        idata_1  = {(v1 ? q1[0] : 2'($urandom)), $urandom, $urandom};
        case (ready_mode)
            0:       oready = 1'b1;
            1:       oready = (tcyc % 2) == 0;
            default: oready = $urandom_range(0, 3) != 0;
        endcase
    endtask

    task automatic check();
        int es;
        es = (m_owner == 0) ? 1 : (m_owner == 1) ? 2 : 0;
        chk("sel",      int'(sel),      es);
        chk("busy",     int'(busy),     (m_owner >= 0) ? 1 : 0);
        chk("iready_0", int'(iready_0), ((m_owner == 0) && oready) ? 1 : 0);
        chk("iready_1", int'(iready_1), ((m_owner == 1) && oready) ? 1 : 0);
        chk("err",      int'(err),      int'(m_err));
        chk("flit_cnt", int'(flit_cnt), m_cnt);
        sel_log.push_back(int'(sel));
    endtask

    task automatic model_step();
        bit         v [2];
        logic [1:0] t [2];
        bit         r [2];
        bit         op [2];
        bit         ending;
        int         w;
        v[0] = ivalid_0;
        v[1] = ivalid_1;
        t[0] = idata_0[FLITW-1:FLITW-2];
        t[1] = idata_1[FLITW-1:FLITW-2];
        op   = m_open;
        for (int k = 0; k < 2; k++) begin
            x_exp[k] = v[k] && (m_owner == k) && oready;
            r[k]     = v[k] && (t[k] == T_HEAD);
            if (x_exp[k]) begin
                if (t[k] == T_NONE || (t[k] == T_HEAD && op[k])) m_err = 1'b1;
                else if (t[k] == T_HEAD) m_open[k] = 1'b1;
                else if (t[k] == T_TAIL) m_open[k] = 1'b0;
            end
            if (v[k] && (m_owner != k) && !op[k] && (t[k] == T_DATA || t[k] == T_TAIL))
                m_err = 1'b1;
        end
        if (x_exp[0] || x_exp[1]) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        ending = (m_owner < 0);
        if (m_owner == 0 && x_exp[0] && t[0] == T_TAIL) ending = 1'b1;
        if (m_owner == 1 && x_exp[1] && t[1] == T_TAIL) ending = 1'b1;
        if (r[0] && r[1]) w = m_prio;
        else if (r[0])    w = 0;
        else if (r[1])    w = 1;
        else              w = -1;
        if (ending) begin
            m_owner = w;
            if (w >= 0) m_prio = 1 - w;
        end
    endtask

    // One clock cycle: drive at posedge+1, compare mid-cycle, advance model and sources.
    task automatic cycle();
        drive();
        #3;
        check();
        model_step();
        @(posedge clk);
        #1;
        if (x_exp[0]) begin
            if (q0[0] == T_TAIL) gap[0] = int'($urandom_range(0, max_gap));
            void'(q0.pop_front());
        end else if (gap[0] > 0) gap[0]--;
        if (x_exp[1]) begin
            if (q1[0] == T_TAIL) gap[1] = int'($urandom_range(0, max_gap));
            void'(q1.pop_front());
        end else if (gap[1] > 0) gap[1]--;
        tcyc++;
    endtask

    function automatic bit drained();
        return (q0.size() == 0) && (q1.size() == 0) && (m_owner < 0);
    endfunction

    task automatic run_until_idle(input int maxc);
        int c;
        c = 0;
        while (!drained() && c < maxc) begin
            cycle();
            c++;
        end
        chk("drain_within_budget", int'(drained()), 1);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #2;
        rst_     = 1'b0;
        ivalid_0 = 1'b0;
        ivalid_1 = 1'b0;
        q0.delete();
        q1.delete();
        gap[0] = 0;
        gap[1] = 0;
        model_reset();
        #1;
        chk("rst_sel",    int'(sel),      0);
        chk("rst_busy",   int'(busy),     0);
        chk("rst_iready", int'({iready_1, iready_0}), 0);
        chk("rst_err",    int'(err),      0);
        chk("rst_cnt",    int'(flit_cnt), 0);
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        sel_log.delete();
        tcyc = 0;
    endtask

    function automatic int count_sel(input int v);
        int n;
        n = 0;
        foreach (sel_log[i]) if (sel_log[i] == v) n++;
        return n;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad;
        int total;
        int len;
        rst_       = 1'b1;
        ivalid_0   = 1'b0;
        ivalid_1   = 1'b0;
        idata_0    = '0;
        idata_1    = '0;
        oready     = 1'b1;
        max_gap    = 0;
        ready_mode = 0;
        tcyc       = 0;
        gap[0]     = 0;
        gap[1]     = 0;
        model_reset();
        @(posedge clk);
        #1;

        // Single 22-flit packet on input 1.
        do_reset();
        push_pkt(1, 22);
        run_until_idle(100);
        chk("t2_req_cycle_sel", sel_log[0], 0);
        chk("t2_first_gnt_sel", sel_log[1], 2);
        chk("t2_sel10_cycles",  count_sel(2), 22);
        chk("t2_cnt",           int'(flit_cnt), 22);
        chk("t2_err",           int'(err), 0);

        // Simultaneous heads: input 0 first, input 1 with no bubble.
        do_reset();
        push_pkt(0, 22);
        push_pkt(1, 22);
        run_until_idle(200);
        bad = (sel_log.size() < 45) ? 1 : 0;
        for (int i = 1; i < 45 && i < sel_log.size(); i++)
            if (sel_log[i] != ((i <= 22) ? 1 : 2)) bad++;
        chk("t3_sel_sequence_errors", bad, 0);
        chk("t3_cnt", int'(flit_cnt), 44);

        // Fairness: 10 back-to-back 3-flit packets per input.
        do_reset();
        for (int p = 0; p < 10; p++) begin
            push_pkt(0, 3);
            push_pkt(1, 3);
        end
        run_until_idle(300);
        bad = (sel_log.size() < 61) ? 1 : 0;
        for (int i = 1; i < 61 && i < sel_log.size(); i++)
            if (sel_log[i] != ((((i - 1) / 3) % 2 == 0) ? 1 : 2)) bad++;
        chk("t4_alternation_errors", bad, 0);
        chk("t4_cnt", int'(flit_cnt), 60);

        // Backpressure: oready 1,0,1,0... across an 8-flit packet.
        do_reset();
        ready_mode = 1;
        push_pkt(0, 8);
        run_until_idle(100);
        chk("t5_gnt_cycles", count_sel(1), 16);
        chk("t5_cnt", int'(flit_cnt), 8);
        ready_mode = 0;

        // Stray DATA flit on input 0 with no open packet.
        do_reset();
        q0.push_back(T_DATA);
        cycle();
        q0.delete();
        chk("t6_err_set", int'(err), 1);
        chk("t6_cnt", int'(flit_cnt), 0);
        cycle();
        cycle();

        // HEAD inside a granted packet: error, grant held to the tail.
        do_reset();
        q0.push_back(T_HEAD);
        q0.push_back(T_DATA);
        q0.push_back(T_HEAD);
        q0.push_back(T_DATA);
        q0.push_back(T_TAIL);
        run_until_idle(100);
        chk("t7_err_set", int'(err), 1);
        chk("t7_gnt_cycles", count_sel(1), 5);

        // Reset at flit 5 of an input-0 packet, then a tie must favour input 0 again.
        do_reset();
        push_pkt(0, 12);
        for (int i = 0; i < 6; i++) cycle();
        chk("t8_pre_cnt", int'(flit_cnt), 5);
        chk("t8_pre_busy", int'(busy), 1);
        do_reset();
        push_pkt(0, 3);
        push_pkt(1, 3);
        run_until_idle(100);
        chk("t8_tie_winner_sel", sel_log[1], 1);
        chk("t8_input1_gnt_sel", sel_log[4], 2);
        chk("t8_cnt", int'(flit_cnt), 6);

        // Random legal traffic with random gaps and backpressure.
        do_reset();
        ready_mode = 2;
        max_gap    = 3;
        gap[0]     = int'($urandom_range(0, 3));
        gap[1]     = int'($urandom_range(0, 3));
        total      = 0;
        for (int p = 0; p < 30; p++) begin
            for (int k = 0; k < 2; k++) begin
                len = int'($urandom_range(2, 6));
                push_pkt(k, len);
                total += len;
            end
        end
        run_until_idle(5000);
        chk("t9_err", int'(err), 0);
        chk("t9_cnt", int'(flit_cnt), total);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
